// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encodings for the pipeline stage controller
package pipe_pkg;
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;
  typedef enum logic [1:0] {
    EMPTY = ST_EMPTY,
    BUSY  = ST_BUSY,
    FULL  = ST_FULL
  } pipe_state_e;
endpackage

// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl: handshake controller producing register load strobes
module pipe_stage_ctrl
  import pipe_pkg::*;
#(
  parameter bit SKID = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  input  logic out_ready,
  output logic load_out,
  output logic load_skid,
  output logic sel_skid,
  output logic in_ready,
  output logic out_valid
);
  if (SKID) begin : g_skid
    pipe_state_e state_q, state_d;
    logic in_ready_q, out_valid_q;
    always_comb begin
      state_d   = state_q;
      load_out  = 1'b0;
      load_skid = 1'b0;
      sel_skid  = 1'b0;
      case (state_q)
        EMPTY: if (in_valid) begin
          load_out = 1'b1;
          state_d  = BUSY;
        end
        BUSY: if (in_valid && out_ready) load_out = 1'b1;
          else if (in_valid) begin
            load_skid = 1'b1;
            state_d   = FULL;
          end else if (out_ready) state_d = EMPTY;
        FULL: if (out_ready) begin
          load_out = 1'b1;
          sel_skid = 1'b1;
          state_d  = BUSY;
        end
        default: state_d = EMPTY;
      endcase
      if (flush) begin
        state_d   = EMPTY;
        load_out  = 1'b0;
        load_skid = 1'b0;
        sel_skid  = 1'b0;
      end
    end
    // handshake outputs are registered decodes of the next state
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q     <= EMPTY;
        in_ready_q  <= 1'b1;
        out_valid_q <= 1'b0;
      end else begin
        state_q     <= state_d;
        in_ready_q  <= state_d != FULL;
        out_valid_q <= state_d != EMPTY;
      end
    end
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
  end else begin : g_noskid
    logic out_valid_q, out_valid_d;
    always_comb begin
      in_ready    = !out_valid_q || out_ready;
      load_out    = in_valid && in_ready && !flush;
      load_skid   = 1'b0;
      sel_skid    = 1'b0;
      out_valid_d = !flush && (load_out || (out_valid_q && !out_ready));
    end
    always_ff @(posedge clk) begin
      if (rst) out_valid_q <= 1'b0;
      else out_valid_q <= out_valid_d;
    end
    assign out_valid = out_valid_q;
  end
endmodule

// File: rtl/pipe_stage.sv
// pipe_stage: valid/ready pipeline register with flush and optional skid slot
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int              WIDTH     = 32,
  parameter bit              SKID      = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  logic load_out, load_skid, sel_skid;
  logic [WIDTH-1:0] out_q, out_d, skid_q, skid_d;
  pipe_stage_ctrl #(.SKID(SKID)) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .load_out  (load_out),
    .load_skid (load_skid),
    .sel_skid  (sel_skid),
    .in_ready  (in_ready),
    .out_valid (out_valid)
  );
  // with SKID=0 the skid strobes are constant zero, so the skid register folds away
  always_comb begin
    out_d  = load_out ? (sel_skid ? skid_q : in_data) : out_q;
    skid_d = load_skid ? in_data : skid_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else begin
      out_q  <= out_d;
      skid_q <= skid_d;
    end
  end
  assign out_data = out_q;
endmodule
